// File: rtl/wide_add_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : wide_add_sequencer
// Description : Multi-precision add/subtract controller that reuses one W-bit
//               adder slice over WORDS slices, LSB first, with a registered
//               inter-slice carry and valid/ready handshakes on both sides.
// Revision    : 1.0 - initial release
// ============================================================================
module wide_add_sequencer #(
  parameter int WORDS = 4,
  parameter int W     = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WORDS*W-1:0] a,
  input  logic [WORDS*W-1:0] b,
  input  logic               cin,
  input  logic               sub,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WORDS*W-1:0] sum,
  output logic               cout,
  output logic               ovf
);

  localparam int c_IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int c_TOT_W = WORDS * W;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [c_IDX_W-1:0]   idx_q, idx_d;
  logic                 carry_q, carry_d;
  logic [c_TOT_W-1:0]   a_q, a_d;
  logic [c_TOT_W-1:0]   b_q, b_d;
  logic [c_TOT_W-1:0]   sum_q, sum_d;
  logic                 cout_q, cout_d;
  logic                 ovf_q, ovf_d;

  logic [W-1:0]         w_a_sl;
  logic [W-1:0]         w_b_sl;
  logic [W:0]           w_add;
  logic                 w_last;

  // Shared slice: select the current operand slices and run the single adder.
  always_comb begin
    w_a_sl = '0;
    w_b_sl = '0;
    for (int k = 0; k < WORDS; k++) begin
      if (idx_q == c_IDX_W'(k)) begin
        w_a_sl = a_q[k*W +: W];
        w_b_sl = b_q[k*W +: W];
      end
    end
    w_add  = {1'b0, w_a_sl} + {1'b0, w_b_sl} + {{W{1'b0}}, carry_q};
    w_last = (idx_q == c_IDX_W'(WORDS - 1));
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          // Subtraction is a + ~b + ~borrow, so the adder never changes.
          a_d     = a;
          b_d     = sub ? ~b : b;
          carry_d = sub ? ~cin : cin;
          idx_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        for (int k = 0; k < WORDS; k++) begin
          if (idx_q == c_IDX_W'(k)) begin
            sum_d[k*W +: W] = w_add[W-1:0];
          end
        end
        carry_d = w_add[W];
        if (w_last) begin
          idx_d   = '0;
          cout_d  = w_add[W];
          ovf_d   = (a_q[c_TOT_W-1] == b_q[c_TOT_W-1]) &&
                    (w_add[W-1] != a_q[c_TOT_W-1]);
          state_d = S_DONE;
        end else begin
          idx_d = idx_q + c_IDX_W'(1);
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

endmodule
`default_nettype wire
